// File: rtl/sum_res_driver_pkg.sv
// Shared definitions for the sign-magnitude adder sweep driver: FSM encoding,
// sweep geometry and counter widths.
package sum_res_driver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int NUM_VECTORS = 1024;
  localparam int IDX_W       = 10;
  localparam int MAG_MAX     = 15;
  localparam int CNT_W       = 11;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECTORS - 1);

  // Counters hold at all-ones rather than wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sum_res_driver_model.sv
// Combinational golden model of a sign-magnitude add: produces the expected
// sign and a 5-bit magnitude so that overflow past 15 stays visible.
module sum_res_model
  import sum_res_driver_pkg::*;
(
  input  logic       SA,
  input  logic [3:0] A,
  input  logic       SB,
  input  logic [3:0] B,
  output logic       exp_sign,
  output logic [4:0] exp_mag
);

  always_comb begin
    exp_sign = SA;
    exp_mag  = 5'd0;
    if (SA == SB) begin
      exp_mag = {1'b0, A} + {1'b0, B};
    end else if (A >= B) begin
      exp_mag = {1'b0, A - B};
    end else begin
      exp_sign = SB;
      exp_mag  = {1'b0, B - A};
    end
  end

endmodule

// File: rtl/sum_res_driver.sv
// Exhaustive sweep driver: walks all 1024 signed operand pairs through an
// external sign-magnitude adder and scores its results against sum_res_model.
module sum_res_driver
  import sum_res_driver_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [3:0]       A,
  output logic             SA,
  output logic [3:0]       B,
  output logic             SB,
  input  logic [3:0]       C,
  input  logic             SC,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] skip_count,
  output logic             fail_valid,
  output logic [IDX_W-1:0] fail_idx
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [3:0]       settle_cnt;

  logic             exp_sign;
  logic [4:0]       exp_mag;
  logic             skip;
  logic             mismatch;

  sum_res_model u_model (
    .SA       (SA),
    .A        (A),
    .SB       (SB),
    .B        (B),
    .exp_sign (exp_sign),
    .exp_mag  (exp_mag)
  );

  // A zero result may legally come back as negative zero, so only the
  // magnitude is scored in that case.
  always_comb begin
    skip     = (exp_mag > 5'(MAG_MAX));
    mismatch = 1'b0;
    if (!skip) begin
      if (exp_mag == 5'd0) begin
        mismatch = (C != 4'd0);
      end else begin
        mismatch = ({SC, C} != {exp_sign, exp_mag[3:0]});
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      idx        <= '0;
      settle_cnt <= '0;
      A          <= '0;
      SA         <= 1'b0;
      B          <= '0;
      SB         <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      skip_count <= '0;
      fail_valid <= 1'b0;
      fail_idx   <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state             <= ST_DRIVE;
            idx               <= '0;
            settle_cnt        <= '0;
            {SA, A, SB, B}    <= '0;
            busy              <= 1'b1;
            done              <= 1'b0;
            pass              <= 1'b0;
            err_count         <= '0;
            skip_count        <= '0;
            fail_valid        <= 1'b0;
            fail_idx          <= '0;
          end
        end

        ST_DRIVE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state      <= ST_CHECK;
            settle_cnt <= '0;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end

        ST_CHECK: begin
          if (skip) begin
            skip_count <= sat_inc(skip_count);
          end else if (mismatch) begin
            err_count <= sat_inc(err_count);
            if (!fail_valid) begin
              fail_valid <= 1'b1;
              fail_idx   <= idx;
            end
          end
          // Operands advance together with idx so they stay put for the
          // whole DRIVE/CHECK window of each vector.
          if (idx == LAST_IDX) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_count == '0) && !mismatch;
          end else begin
            idx            <= idx + 1'b1;
            {SA, A, SB, B} <= idx + 1'b1;
            state          <= ST_DRIVE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sum_res_driver.sv
// Directed/randomized bench: two drivers (SETTLE=1 and 3) each attached to a
// behavioural adder with injectable faults, scored against a signed-integer model.
module tb_sum_res_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic start;
  logic sel;  // 0: SETTLE=1 instance, 1: SETTLE=3 instance

  logic [3:0]  a1, b1, c1, a3, b3, c3;
  logic        sa1, sb1, sc1, sa3, sb3, sc3;
  logic        busy1, done1, pass1, fv1, busy3, done3, pass3, fv3;
  logic [10:0] err1, skip1, err3, skip3;
  logic [9:0]  fidx1, fidx3;

  // Adder fault knobs
  logic       stuck0;
  logic       negzero;
  logic [4:0] corrupt_mask [1024];

  int total = 0;
  int bad   = 0;
  int opnd_bad;
  logic [31:0] snap_err, snap_skip, snap_fv, snap_done;

  sum_res_driver #(.SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start && !sel),
    .A(a1), .SA(sa1), .B(b1), .SB(sb1), .C(c1), .SC(sc1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .skip_count(skip1), .fail_valid(fv1), .fail_idx(fidx1)
  );

  sum_res_driver #(.SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start && sel),
    .A(a3), .SA(sa3), .B(b3), .SB(sb3), .C(c3), .SC(sc3),
    .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
    .skip_count(skip3), .fail_valid(fv3), .fail_idx(fidx3)
  );

  // Signed value of a sign-magnitude operand
  function automatic int smval(input logic s, input logic [3:0] m);
    return s ? -int'(m) : int'(m);
  endfunction

  // Behavioural adder under test, including injected faults
  function automatic logic [4:0] adder(input logic sa, input logic [3:0] a,
                                       input logic sb, input logic [3:0] b);
    int s, m;
    logic [4:0] r;
    s = smval(sa, a) + smval(sb, b);
    m = (s < 0) ? -s : s;
    r = {s < 0, m[3:0]};
    if (m == 0 && negzero) r[4] = 1'b1;
    if (stuck0) r[0] = 1'b0;
    r = r ^ corrupt_mask[{sa, a, sb, b}];
    return r;
  endfunction

  // Adder results settle half a cycle after the operands move.
  always @(negedge clk) begin
    {sc1, c1} <= adder(sa1, a1, sb1, b1);
    {sc3, c3} <= adder(sa3, a3, sb3, b3);
  end

  logic        cur_busy, cur_done, cur_pass, cur_fv;
  logic [10:0] cur_err, cur_skip;
  logic [9:0]  cur_fidx, cur_opnd;
  int          cur_settle;
  always_comb begin
    if (!sel) begin
      cur_busy = busy1; cur_done = done1; cur_pass = pass1; cur_fv = fv1;
      cur_err = err1; cur_skip = skip1; cur_fidx = fidx1;
      cur_opnd = {sa1, a1, sb1, b1}; cur_settle = 1;
    end else begin
      cur_busy = busy3; cur_done = done3; cur_pass = pass3; cur_fv = fv3;
      cur_err = err3; cur_skip = skip3; cur_fidx = fidx3;
      cur_opnd = {sa3, a3, sb3, b3}; cur_settle = 3;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: score every vector with plain signed arithmetic.
  task automatic model_sweep(output int e, output int s, output int fi);
    logic [9:0] id;
    int truth, got_v;
    logic [4:0] got;
    e = 0; s = 0; fi = -1;
    for (int i = 0; i < 1024; i++) begin
      id    = 10'(i);
      truth = smval(id[9], id[8:5]) + smval(id[4], id[3:0]);
      got   = adder(id[9], id[8:5], id[4], id[3:0]);
      got_v = smval(got[4], got[3:0]);
      if (truth > 15 || truth < -15) s++;
      else if (got_v != truth) begin
        e++;
        if (fi < 0) fi = i;
      end
    end
  endtask

  // Pulse start, then count busy cycles while tracking operand progression.
  task automatic sweep(input int restart_at, output int len);
    len = 0;
    opnd_bad = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    snap_err  = 32'(cur_err);
    snap_skip = 32'(cur_skip);
    snap_fv   = 32'(cur_fv);
    snap_done = 32'(cur_done);
    while (cur_busy && len < 20000) begin
      if (cur_opnd !== 10'(len / (cur_settle + 1))) opnd_bad++;
      start = (len == restart_at);
      len++;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic check_results(input string tag, input int exp_len, input int len);
    int e, s, fi;
    model_sweep(e, s, fi);
    chk({tag, "_busy_len"}, 32'(len), 32'(exp_len));
    chk({tag, "_opnd_track"}, 32'(opnd_bad), 32'd0);
    chk({tag, "_done"}, 32'(cur_done), 32'd1);
    chk({tag, "_busy_after"}, 32'(cur_busy), 32'd0);
    chk({tag, "_err"}, 32'(cur_err), 32'(e));
    chk({tag, "_skip"}, 32'(cur_skip), 32'(s));
    chk({tag, "_fail_valid"}, 32'(cur_fv), 32'(fi >= 0));
    chk({tag, "_fail_idx"}, 32'(cur_fidx), (fi >= 0) ? 32'(fi) : 32'd0);
    chk({tag, "_pass"}, 32'(cur_pass), 32'(e == 0));
    $display("sweep %s: len=%0d err=%0d skip=%0d fail_valid=%0d fail_idx=%0d pass=%0d",
             tag, len, cur_err, cur_skip, cur_fv, cur_fidx, cur_pass);
  endtask

  task automatic clear_faults();
    stuck0 = 1'b0;
    negzero = 1'b0;
    for (int i = 0; i < 1024; i++) corrupt_mask[i] = 5'd0;
  endtask

  task automatic check_zero_state(input string tag);
    chk({tag, "_busy"}, 32'(cur_busy), 32'd0);
    chk({tag, "_done"}, 32'(cur_done), 32'd0);
    chk({tag, "_pass"}, 32'(cur_pass), 32'd0);
    chk({tag, "_err"}, 32'(cur_err), 32'd0);
    chk({tag, "_skip"}, 32'(cur_skip), 32'd0);
    chk({tag, "_fail_valid"}, 32'(cur_fv), 32'd0);
    chk({tag, "_fail_idx"}, 32'(cur_fidx), 32'd0);
    chk({tag, "_operands"}, 32'(cur_opnd), 32'd0);
  endtask

  initial begin
    int len, cnt;
    rst_n = 1'b0;
    start = 1'b0;
    sel   = 1'b0;
    clear_faults();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_zero_state("reset");

    // Clean sweep with a correct adder
    sweep(-1, len);
    check_results("clean", 2048, len);

    // C[0] stuck at 0: first mismatch is idx 1 (0+1)
    stuck0 = 1'b1;
    sweep(-1, len);
    check_results("stuck0", 2048, len);
    chk("stuck0_fail_idx_is_1", 32'(cur_fidx), 32'd1);

    // Restart from DONE after a failing run; adder now returns negative zero
    clear_faults();
    negzero = 1'b1;
    sweep(-1, len);
    chk("restart_clr_err", snap_err, 32'd0);
    chk("restart_clr_skip", snap_skip, 32'd0);
    chk("restart_clr_fv", snap_fv, 32'd0);
    chk("restart_clr_done", snap_done, 32'd0);
    check_results("negzero", 2048, len);

    // Random fault patterns
    for (int it = 0; it < 3; it++) begin
      clear_faults();
      negzero = 1'($urandom_range(0, 1));
      for (int i = 0; i < 1024; i++)
        if ($urandom_range(0, 63) == 0) corrupt_mask[i] = 5'($urandom_range(1, 31));
      sweep(-1, len);
      check_results($sformatf("rand%0d", it), 2048, len);
    end
    clear_faults();

    // Start while busy is ignored
    sweep(100, len);
    check_results("busy_start", 2048, len);

    // Reset for one cycle at sweep cycle 500
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cnt = 0;
    while (cnt < 500 && cur_busy) begin
      cnt++;
      @(negedge clk);
    end
    chk("midreset_reached_500", 32'(cnt), 32'd500);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_zero_state("midreset");
    repeat (5) @(negedge clk);
    chk("midreset_stays_idle", 32'(cur_busy), 32'd0);
    sweep(-1, len);
    check_results("after_reset", 2048, len);

    // SETTLE=3 instance
    sel = 1'b1;
    @(negedge clk);
    chk("settle3_idle_busy", 32'(cur_busy), 32'd0);
    sweep(-1, len);
    check_results("settle3", 4096, len);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
